keypad_emulator: RTL and testbench

- Models the 4x4 matrix keypad as seen by the keypad scanner/debounce/registration chain.
- The scanner drives active-low columns into `columnas`. The block pulls the matching `filas` line low when its emulated key is closed and that key's column is being driven.
- A command port (valid/ready) schedules press/hold/release sequences, with LFSR contact bounce on both edges.
- Used in benches and in self-test builds to exercise the scanner and debounce end to end without a physical keypad.

---
 rtl/keypad_emulator.sv | 169 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates one closed key of a 4x4 active-low matrix keypad.
// A valid/ready command schedules press -> hold -> release -> gap, and the
// selected row line is pulled low only while the contact is closed and the
// scanner drives that key's column.
// Optional feature macro: KEYEMU_BOUNCE_EN adds LFSR contact bounce windows
// on both edges. Without it the contact is a clean step.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES = 64,
    parameter int GAP_CYCLES    = 16,
    parameter int HOLD_W        = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        columnas,
    output logic [3:0]        filas,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_fila,
    input  logic [1:0]        cmd_col,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              cmd_abort,
    output logic              busy,
    output logic              done,
    output logic              contact
);

    // One shared counter, wide enough for every state's limit.
    localparam int BW    = $clog2(BOUNCE_CYCLES + 1);
    localparam int GW    = $clog2(GAP_CYCLES + 1);
    localparam int CW1   = (HOLD_W > BW) ? HOLD_W : BW;
    localparam int CNT_W = (CW1 > GW) ? CW1 : GW;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        REL_BOUNCE,
        GAP
    } state_t;

`ifdef KEYEMU_BOUNCE_EN
    localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'(BOUNCE_CYCLES - 1);
    localparam state_t AFTER_ACCEPT = PRESS_BOUNCE;
    localparam state_t AFTER_HOLD   = REL_BOUNCE;

    // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [7:0] lfsr;
`else
    localparam state_t AFTER_ACCEPT = HOLD;
    localparam state_t AFTER_HOLD   = GAP;
`endif

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        fila_q;
    logic [1:0]        col_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  hold_last;
    logic              accept;

    assign accept    = cmd_valid && cmd_ready;
    assign hold_last = CNT_W'(hold_q) - CNT_W'(1);

    // Command fields captured on acceptance; a zero hold is promoted to one cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            fila_q <= cmd_fila;
            col_q  <= cmd_col;
            hold_q <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
        end
    end

    // Sequencer: state, counter, LFSR and all registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b0;
            contact   <= 1'b0;
`ifdef KEYEMU_BOUNCE_EN
            lfsr      <= 8'hA5;
`endif
        end else begin
            done <= 1'b0;
`ifdef KEYEMU_BOUNCE_EN
            contact <= (state == HOLD) ||
                       (((state == PRESS_BOUNCE) || (state == REL_BOUNCE)) && lfsr[0]);
`else
            contact <= (state == HOLD);
`endif
            case (state)
                IDLE: begin
                    // Abort is ignored here, so an accept always wins.
                    cmd_ready <= !accept;
                    busy      <= accept;
                    if (accept) begin
                        state <= AFTER_ACCEPT;
                        cnt   <= '0;
                    end
                end
`ifdef KEYEMU_BOUNCE_EN
                PRESS_BOUNCE: begin
                    lfsr <= lfsr_next(lfsr);
                    if (cmd_abort) begin
                        state <= REL_BOUNCE;
                        cnt   <= '0;
                    end else if (cnt == BNC_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                REL_BOUNCE: begin
                    lfsr <= lfsr_next(lfsr);
                    if (cnt == BNC_LAST) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                HOLD: begin
                    if (cmd_abort || (cnt == hold_last)) begin
                        state <= AFTER_HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // Row drive: only the latched row goes low, and only while its column is scanned.
    always_comb begin
        filas = 4'b1111;
        if (contact && !columnas[col_q]) begin
            filas[fila_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized bench for keypad_emulator with a timeline
// reference model (per-cycle expected contact/busy/done/ready after accept).
module tb_keypad_emulator;

    localparam int BC = 8;
    localparam int GC = 16;
    localparam int HW = 24;
`ifdef KEYEMU_BOUNCE_EN
    localparam int BE = BC;
`else
    localparam int BE = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    columnas = 4'hF;
    logic [3:0]    filas;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_fila = 2'd0;
    logic [1:0]    cmd_col = 2'd0;
    logic [HW-1:0] cmd_hold = '0;
    logic          cmd_abort = 1'b0;
    logic          busy;
    logic          done;
    logic          contact;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] lfsr_m = 8'hA5;

    always #5 clk = ~clk;

    keypad_emulator #(
        .BOUNCE_CYCLES(BC),
        .GAP_CYCLES(GC),
        .HOLD_W(HW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .columnas(columnas),
        .filas(filas),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_fila(cmd_fila),
        .cmd_col(cmd_col),
        .cmd_hold(cmd_hold),
        .cmd_abort(cmd_abort),
        .busy(busy),
        .done(done),
        .contact(contact)
    );

    // Reference polynomial x^8+x^6+x^5+x^4+1 applied to a plain byte.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    // Offer one command, then follow its whole timeline cycle by cycle.
    // colmode: -1 random columns, -2 walk 1110/1101/1011/0111, else fixed value.
    // abort_k: edge index (after acceptance) at which abort is sampled, -1 none.
    // stop_k:  stop checking after this index, -1 to run to done.
    task automatic do_seq(input int f, input int c, input int h, input int abort_k,
                          input int stop_k, input int colmode, input bit keep_valid);
        int heff, t_end, last, guard;
        logic [3:0] cols, exp_f, pat;
        logic exp_c;
        heff = (h == 0) ? 1 : h;
        if (abort_k >= 0) heff = abort_k - BE;
        t_end = 2 * BE + heff + GC;
        last  = (stop_k >= 0) ? stop_k : t_end;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (cmd_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_wait: cmd_ready=%b required 1 within 2000 cycles", cmd_ready);
            return;
        end
        cmd_fila  = 2'(f);
        cmd_col   = 2'(c);
        cmd_hold  = HW'(h);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) cmd_valid = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (keep_valid) begin
                cmd_fila = 2'($urandom);
                cmd_col  = 2'($urandom);
                cmd_hold = HW'($urandom_range(0, 5));
            end
            cmd_abort = (abort_k >= 0) && (k == abort_k - 1);
            if (colmode == -1) begin
                cols = 4'($urandom);
            end else if (colmode == -2) begin
                pat  = 4'b1110;
                cols = (k % 4 == 0) ? pat : (k % 4 == 1) ? 4'b1101 :
                       (k % 4 == 2) ? 4'b1011 : 4'b0111;
            end else begin
                cols = colmode[3:0];
            end
            columnas = cols;
            #1;
            if ((k >= 1 && k <= BE) || (k >= BE + heff + 1 && k <= 2 * BE + heff)) begin
                exp_c  = lfsr_m[0];
                lfsr_m = lfsr_step(lfsr_m);
            end else begin
                exp_c = (k >= BE + 1) && (k <= BE + heff);
            end
            exp_f = 4'b1111;
            if (exp_c && !cols[c]) exp_f[f] = 1'b0;
            n_cmp++;
            if (contact !== exp_c) begin
                n_bad++;
                $display("FAIL contact k=%0d: got %b required %b", k, contact, exp_c);
            end
            n_cmp++;
            if (filas !== exp_f) begin
                n_bad++;
                $display("FAIL filas k=%0d cols=%b: got %b required %b", k, cols, filas, exp_f);
            end
            n_cmp++;
            if (busy !== (k < t_end)) begin
                n_bad++;
                $display("FAIL busy k=%0d: got %b required %b", k, busy, (k < t_end));
            end
            n_cmp++;
            if (done !== (k == t_end)) begin
                n_bad++;
                $display("FAIL done k=%0d: got %b required %b", k, done, (k == t_end));
            end
            n_cmp++;
            if (cmd_ready !== (k >= t_end)) begin
                n_bad++;
                $display("FAIL cmd_ready k=%0d: got %b required %b", k, cmd_ready, (k >= t_end));
            end
        end
        cmd_abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; columnas = 4'b0000; cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (filas !== 4'b1111) begin n_bad++; $display("FAIL rst_filas: got %b required 1111", filas); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b required 0", done); end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b required 0", cmd_ready); end
        n_cmp++;
        if (contact !== 1'b0) begin n_bad++; $display("FAIL rst_contact: got %b required 0", contact); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b required 1", cmd_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rel_busy: got %b required 0", busy); end
        lfsr_m = 8'hA5;
    endtask

    task automatic test_single_press();
        do_seq(1, 1, 100, -1, -1, 4'b1101, 1'b0);
    endtask

    task automatic test_column_gating();
        do_seq(1, 1, 40, -1, -1, -2, 1'b0);
    endtask

    task automatic test_abort();
        do_seq(0, 0, 1000, BE + 10, -1, 4'b1110, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_seq(2, 3, 20, -1, -1, -1, 1'b1);
        do_seq(3, 2, 0, -1, -1, -1, 1'b1);
        do_seq(1, 2, 0, -1, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        int h, ab;
        for (int i = 0; i < 6; i++) begin
            h  = $urandom_range(0, 30);
            ab = -1;
            if ($urandom_range(0, 2) == 0 && h >= 3) ab = BE + $urandom_range(1, h - 1);
            do_seq($urandom_range(0, 3), $urandom_range(0, 3), h, ab, -1, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_seq(3, 0, 50, -1, BE + 5, 4'b1110, 1'b0);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (filas !== 4'b1111) begin n_bad++; $display("FAIL mid_rst_filas: got %b required 1111", filas); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
        n_cmp++;
        if (contact !== 1'b0) begin n_bad++; $display("FAIL mid_rst_contact: got %b required 0", contact); end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rel_ready: got %b required 1", cmd_ready); end
        lfsr_m = 8'hA5;
        do_seq(2, 1, 5, -1, -1, -1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_column_gating();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
